// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_pkg
// Description : Shared types and constants for the RISC-V vector CSR block:
//               VS context states, CSR layouts, vsew/vlmul encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

    localparam int RISCV_V_VLEN         = 128;
    localparam int RISCV_V_ELEN         = 64;
    localparam int RISCV_V_VL_WIDTH     = $clog2(RISCV_V_VLEN) + 1;
    localparam int RISCV_V_VSTART_WIDTH = $clog2(RISCV_V_VLEN);

    // vlmul encodings
    localparam logic [2:0] RISCV_V_VLMUL_1    = 3'b000;
    localparam logic [2:0] RISCV_V_VLMUL_2    = 3'b001;
    localparam logic [2:0] RISCV_V_VLMUL_4    = 3'b010;
    localparam logic [2:0] RISCV_V_VLMUL_8    = 3'b011;
    localparam logic [2:0] RISCV_V_VLMUL_RSVD = 3'b100;
    localparam logic [2:0] RISCV_V_VLMUL_F8   = 3'b101;
    localparam logic [2:0] RISCV_V_VLMUL_F4   = 3'b110;
    localparam logic [2:0] RISCV_V_VLMUL_F2   = 3'b111;

    // vsew encodings
    localparam logic [2:0] RISCV_V_VSEW_8  = 3'b000;
    localparam logic [2:0] RISCV_V_VSEW_16 = 3'b001;
    localparam logic [2:0] RISCV_V_VSEW_32 = 3'b010;
    localparam logic [2:0] RISCV_V_VSEW_64 = 3'b011;

    typedef enum logic [1:0] {
        RISCV_V_VS_OFF     = 2'd0,
        RISCV_V_VS_INITIAL = 2'd1,
        RISCV_V_VS_CLEAN   = 2'd2,
        RISCV_V_VS_DIRTY   = 2'd3
    } riscv_v_vs_state_e;

    // vs sits at bits [10:9], matching its placement in the status CSR
    typedef struct packed {
        logic [20:0]       rsvd_hi;
        riscv_v_vs_state_e vs;
        logic [8:0]        rsvd_lo;
    } riscv_v_vsstatus_t;

    typedef struct packed {
        logic        vill;
        logic [22:0] rsvd;
        logic        vma;
        logic        vta;
        logic [2:0]  vsew;
        logic [2:0]  vlmul;
    } riscv_v_vtype_t;

    typedef struct packed {
        logic [RISCV_V_VL_WIDTH-1:0] len;
    } riscv_v_vl_t;

    typedef struct packed {
        logic [RISCV_V_VSTART_WIDTH-1:0] index;
    } riscv_v_vstart_t;

    typedef struct packed {
        logic [1:0] rounding_mode;
    } riscv_v_vxrm_t;

    typedef struct packed {
        logic saturate;
    } riscv_v_vxsat_t;

endpackage
`default_nettype wire

// File: rtl/riscv_v_vlmax_calc.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_vlmax_calc
// Description : Combinational vtype legality check and VLMAX computation.
//               The vill bit of the input is ignored; only the fields count.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_v_vlmax_calc
    import riscv_v_pkg::*;
#(
    parameter int VLEN = RISCV_V_VLEN,
    parameter int ELEN = RISCV_V_ELEN
) (
    input  riscv_v_vtype_t               i_vtype,
    output logic                         o_legal,
    output logic [RISCV_V_VL_WIDTH-1:0]  o_vlmax
);

    localparam int                          c_ELEN_LOG2 = $clog2(ELEN);
    localparam logic [RISCV_V_VL_WIDTH-1:0] c_VLEN_VEC  = RISCV_V_VL_WIDTH'(VLEN);

    logic                        w_frac;
    logic [2:0]                  w_frac_shift;
    logic [3:0]                  w_sew_log2;
    logic                        w_illegal;
    logic [RISCV_V_VL_WIDTH-1:0] w_base;
    logic [RISCV_V_VL_WIDTH-1:0] w_scaled;

    // Decode SEW/LMUL as log2 shifts, check legality and scale VLEN/SEW by LMUL
    always_comb begin
        w_frac       = i_vtype.vlmul[2];
        // 111 -> 1, 110 -> 2, 101 -> 3 (right-shift amount for fractional LMUL)
        w_frac_shift = w_frac ? (3'd4 - {1'b0, i_vtype.vlmul[1:0]}) : 3'd0;
        w_sew_log2   = {1'b0, i_vtype.vsew} + 4'd3;

        w_illegal = i_vtype.vsew[2]
                  | (i_vtype.vlmul == RISCV_V_VLMUL_RSVD)
                  | (w_sew_log2 > 4'(c_ELEN_LOG2))
                  | ((w_sew_log2 + {1'b0, w_frac_shift}) > 4'(c_ELEN_LOG2))
                  | (|i_vtype.rsvd);

        w_base   = c_VLEN_VEC >> w_sew_log2;
        w_scaled = w_frac ? (w_base >> w_frac_shift) : (w_base << i_vtype.vlmul[1:0]);

        o_legal  = ~w_illegal;
        o_vlmax  = w_illegal ? '0 : w_scaled;
    end

endmodule
`default_nettype wire

// File: rtl/riscv_v_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_csr_file
// Description : Architectural storage for the vector CSRs (vsstatus, vtype,
//               vl, vstart, vxrm, vxsat) with vsstatus.VS context tracking.
//               Optional macro RISCV_V_CSR_BYPASS_EN enables same-cycle
//               write-through of committed values onto the ID outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_v_csr_file
    import riscv_v_pkg::*;
#(
    parameter int VLEN = RISCV_V_VLEN,
    parameter int ELEN = RISCV_V_ELEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_stall,
    input  logic                         i_csr_wr_en_vsstatus_exe,
    input  logic                         i_csr_wr_en_vtype_exe,
    input  logic                         i_csr_wr_en_vl_exe,
    input  logic                         i_csr_wr_en_vstart_exe,
    input  logic                         i_csr_wr_en_vxrm_exe,
    input  logic                         i_csr_wr_en_vxsat_exe,
    input  riscv_v_vsstatus_t            i_csr_wr_data_vsstatus_exe,
    input  riscv_v_vtype_t               i_csr_wr_data_vtype_exe,
    input  riscv_v_vl_t                  i_csr_wr_data_vl_exe,
    input  riscv_v_vstart_t              i_csr_wr_data_vstart_exe,
    input  riscv_v_vxrm_t                i_csr_wr_data_vxrm_exe,
    input  riscv_v_vxsat_t               i_csr_wr_data_vxsat_exe,
    input  logic                         i_vec_dirty_exe,
    output riscv_v_vsstatus_t            o_vsstatus_id,
    output riscv_v_vtype_t               o_vtype_id,
    output riscv_v_vl_t                  o_vl_id,
    output riscv_v_vstart_t              o_vstart_id,
    output riscv_v_vxrm_t                o_vxrm_id,
    output riscv_v_vxsat_t               o_vxsat_id,
    output logic [RISCV_V_VL_WIDTH-1:0]  o_vlmax_id,
    output logic                         o_vs_off_id
);

    riscv_v_vsstatus_t r_vsstatus;
    riscv_v_vtype_t    r_vtype;
    riscv_v_vl_t       r_vl;
    riscv_v_vstart_t   r_vstart;
    riscv_v_vxrm_t     r_vxrm;
    riscv_v_vxsat_t    r_vxsat;

    riscv_v_vsstatus_t w_vsstatus_next;
    riscv_v_vs_state_e w_vs_next;
    riscv_v_vtype_t    w_vtype_next;
    riscv_v_vl_t       w_vl_next;
    riscv_v_vstart_t   w_vstart_next;
    riscv_v_vxrm_t     w_vxrm_next;
    riscv_v_vxsat_t    w_vxsat_next;

    logic w_wr_vsstatus, w_wr_vtype, w_wr_vl, w_wr_vstart, w_wr_vxrm, w_wr_vxsat;
    logic w_ctx_touch;
    logic w_new_legal, w_cur_legal;
    logic [RISCV_V_VL_WIDTH-1:0] w_new_vlmax, w_cur_vlmax, w_cur_vlmax_gated, w_vlmax_eff;

    // Effective commit strobes; a held (stalled) instruction re-presents its writes,
    // and nothing commits or bypasses while reset is asserted
    assign w_wr_vsstatus = i_csr_wr_en_vsstatus_exe & ~i_stall & rst_n;
    assign w_wr_vtype    = i_csr_wr_en_vtype_exe    & ~i_stall & rst_n;
    assign w_wr_vl       = i_csr_wr_en_vl_exe       & ~i_stall & rst_n;
    assign w_wr_vstart   = i_csr_wr_en_vstart_exe   & ~i_stall & rst_n;
    assign w_wr_vxrm     = i_csr_wr_en_vxrm_exe     & ~i_stall & rst_n;
    assign w_wr_vxsat    = i_csr_wr_en_vxsat_exe    & ~i_stall & rst_n;

    assign w_ctx_touch = w_wr_vtype | w_wr_vl | w_wr_vstart | w_wr_vxrm | w_wr_vxsat
                       | (i_vec_dirty_exe & ~i_stall & rst_n);

    riscv_v_vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN)) u_calc_new (
        .i_vtype (i_csr_wr_data_vtype_exe),
        .o_legal (w_new_legal),
        .o_vlmax (w_new_vlmax)
    );

    riscv_v_vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN)) u_calc_cur (
        .i_vtype (r_vtype),
        .o_legal (w_cur_legal),
        .o_vlmax (w_cur_vlmax)
    );

    // A stored illegal vtype is all-zero fields with vill set, which the
    // calculator alone would read as legal, so vill gates the result here
    assign w_cur_vlmax_gated = (w_cur_legal && !r_vtype.vill) ? w_cur_vlmax : '0;

    // vl clamps against the vtype being committed alongside it, if any
    assign w_vlmax_eff = w_wr_vtype ? w_new_vlmax : w_cur_vlmax_gated;

    // Next-state for vtype (legality applied) and vl (clamp, or forced 0 on illegal vtype)
    always_comb begin
        w_vtype_next = r_vtype;
        if (w_wr_vtype) begin
            if (w_new_legal) begin
                w_vtype_next      = i_csr_wr_data_vtype_exe;
                w_vtype_next.vill = 1'b0;
            end else begin
                w_vtype_next      = '0;
                w_vtype_next.vill = 1'b1;
            end
        end

        w_vl_next = r_vl;
        if (w_wr_vtype && !w_new_legal) begin
            w_vl_next.len = '0;
        end else if (w_wr_vl) begin
            w_vl_next.len = (i_csr_wr_data_vl_exe.len > w_vlmax_eff)
                          ? w_vlmax_eff : i_csr_wr_data_vl_exe.len;
        end
    end

    // Next-state for the simple CSRs
    always_comb begin
        w_vstart_next = w_wr_vstart ? i_csr_wr_data_vstart_exe : r_vstart;
        w_vxrm_next   = w_wr_vxrm   ? i_csr_wr_data_vxrm_exe   : r_vxrm;
        w_vxsat_next  = w_wr_vxsat  ? i_csr_wr_data_vxsat_exe  : r_vxsat;
    end

    // VS context state machine: explicit write wins, otherwise any vector activity dirties
    always_comb begin
        w_vs_next = r_vsstatus.vs;
        unique case (r_vsstatus.vs)
            RISCV_V_VS_OFF:     w_vs_next = RISCV_V_VS_OFF;
            RISCV_V_VS_INITIAL,
            RISCV_V_VS_CLEAN,
            RISCV_V_VS_DIRTY:   if (w_ctx_touch) w_vs_next = RISCV_V_VS_DIRTY;
            default:            w_vs_next = r_vsstatus.vs;
        endcase

        w_vsstatus_next = r_vsstatus;
        if (w_wr_vsstatus) begin
            w_vsstatus_next = i_csr_wr_data_vsstatus_exe;
        end else begin
            w_vsstatus_next.vs = w_vs_next;
        end
    end

    // CSR state registers; async reset discards any in-flight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsstatus    <= '0;
            r_vsstatus.vs <= RISCV_V_VS_INITIAL;
            r_vtype       <= '0;
            r_vtype.vill  <= 1'b1;
            r_vl          <= '0;
            r_vstart      <= '0;
            r_vxrm        <= '0;
            r_vxsat       <= '0;
        end else begin
            r_vsstatus    <= w_vsstatus_next;
            r_vtype       <= w_vtype_next;
            r_vl          <= w_vl_next;
            r_vstart      <= w_vstart_next;
            r_vxrm        <= w_vxrm_next;
            r_vxsat       <= w_vxsat_next;
        end
    end

`ifdef RISCV_V_CSR_BYPASS_EN
    // Write-through: next values equal the registers whenever nothing commits
    assign o_vsstatus_id = w_wr_vsstatus ? i_csr_wr_data_vsstatus_exe : r_vsstatus;
    assign o_vtype_id    = w_vtype_next;
    assign o_vl_id       = w_vl_next;
    assign o_vstart_id   = w_vstart_next;
    assign o_vxrm_id     = w_vxrm_next;
    assign o_vxsat_id    = w_vxsat_next;
    assign o_vlmax_id    = w_vlmax_eff;
    assign o_vs_off_id   = (o_vsstatus_id.vs == RISCV_V_VS_OFF);
`else
    assign o_vsstatus_id = r_vsstatus;
    assign o_vtype_id    = r_vtype;
    assign o_vl_id       = r_vl;
    assign o_vstart_id   = r_vstart;
    assign o_vxrm_id     = r_vxrm;
    assign o_vxsat_id    = r_vxsat;
    assign o_vlmax_id    = w_cur_vlmax_gated;
    assign o_vs_off_id   = (r_vsstatus.vs == RISCV_V_VS_OFF);
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_v_csr_file
// Description : Self-checking bench for riscv_v_csr_file: directed vector
//               table, randomized traffic against a reference model, and an
//               asynchronous-reset-during-write sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_v_csr_file;
    import riscv_v_pkg::*;

    localparam int VLEN = 128;
    localparam int ELEN = 64;

    logic clk, rst_n, stall, vec_dirty;
    logic en_vss, en_vt, en_vl, en_vst, en_vxrm, en_vxsat;
    riscv_v_vsstatus_t d_vss;
    riscv_v_vtype_t    d_vt;
    riscv_v_vl_t       d_vl;
    riscv_v_vstart_t   d_vst;
    riscv_v_vxrm_t     d_vxrm;
    riscv_v_vxsat_t    d_vxsat;

    riscv_v_vsstatus_t o_vss;
    riscv_v_vtype_t    o_vt;
    riscv_v_vl_t       o_vl;
    riscv_v_vstart_t   o_vst;
    riscv_v_vxrm_t     o_vxrm;
    riscv_v_vxsat_t    o_vxsat;
    logic [RISCV_V_VL_WIDTH-1:0] o_vlmax;
    logic o_off;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_v_csr_file #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_stall                    (stall),
        .i_csr_wr_en_vsstatus_exe   (en_vss),
        .i_csr_wr_en_vtype_exe      (en_vt),
        .i_csr_wr_en_vl_exe         (en_vl),
        .i_csr_wr_en_vstart_exe     (en_vst),
        .i_csr_wr_en_vxrm_exe       (en_vxrm),
        .i_csr_wr_en_vxsat_exe      (en_vxsat),
        .i_csr_wr_data_vsstatus_exe (d_vss),
        .i_csr_wr_data_vtype_exe    (d_vt),
        .i_csr_wr_data_vl_exe       (d_vl),
        .i_csr_wr_data_vstart_exe   (d_vst),
        .i_csr_wr_data_vxrm_exe     (d_vxrm),
        .i_csr_wr_data_vxsat_exe    (d_vxsat),
        .i_vec_dirty_exe            (vec_dirty),
        .o_vsstatus_id              (o_vss),
        .o_vtype_id                 (o_vt),
        .o_vl_id                    (o_vl),
        .o_vstart_id                (o_vst),
        .o_vxrm_id                  (o_vxrm),
        .o_vxsat_id                 (o_vxsat),
        .o_vlmax_id                 (o_vlmax),
        .o_vs_off_id                (o_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wr bits: [5]vsstatus [4]vtype [3]vl [2]vstart [1]vxrm [0]vxsat
    typedef struct {
        logic [5:0]        wr;
        logic              stall;
        logic              dirty;
        riscv_v_vsstatus_t vss;
        riscv_v_vtype_t    vt;
        logic [7:0]        vl;
        logic [6:0]        vstart;
        logic [1:0]        vxrm;
        logic              vxsat;
        logic              exp_vill;
        int                exp_vl;
        int                exp_vlmax;
        int                exp_vs;
        logic              exp_off;
    } vec_t;

    // Reference model state
    riscv_v_vsstatus_t m_vss;
    riscv_v_vtype_t    m_vt;
    int                m_vl, m_vstart, m_vxrm, m_vxsat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic riscv_v_vtype_t mk_vt(input int rsvd, input int vsew, input int vlmul);
        riscv_v_vtype_t t;
        t       = '0;
        t.rsvd  = 23'(rsvd);
        t.vsew  = 3'(vsew);
        t.vlmul = 3'(vlmul);
        return t;
    endfunction

    function automatic riscv_v_vsstatus_t mk_vss(input int vs);
        riscv_v_vsstatus_t s;
        s    = '0;
        s.vs = riscv_v_vs_state_e'(vs);
        return s;
    endfunction

    function automatic vec_t mk(input logic [5:0] wr, input logic st, input logic dty,
                                input int vs, input riscv_v_vtype_t vt, input int vl,
                                input int vxrm, input int vxsat,
                                input int e_vill, input int e_vl, input int e_vlmax,
                                input int e_vs);
        vec_t v;
        v.wr = wr; v.stall = st; v.dirty = dty;
        v.vss = mk_vss(vs); v.vt = vt; v.vl = 8'(vl); v.vstart = 7'd0;
        v.vxrm = 2'(vxrm); v.vxsat = 1'(vxsat);
        v.exp_vill = 1'(e_vill); v.exp_vl = e_vl; v.exp_vlmax = e_vlmax;
        v.exp_vs = e_vs; v.exp_off = (e_vs == 0);
        return v;
    endfunction

    // Legality from the architectural rules: SEW and LMUL as numbers
    function automatic bit ref_legal(input riscv_v_vtype_t t);
        int sew, den;
        if (t.vsew > 3 || t.vlmul == 3'b100 || t.rsvd != 0) return 1'b0;
        sew = 8 << t.vsew;
        den = (t.vlmul >= 5) ? (1 << (8 - t.vlmul)) : 1;
        if (sew > ELEN) return 1'b0;
        if (sew * den > ELEN) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_vlmax(input riscv_v_vtype_t t);
        int sew, num, den;
        if (t.vill) return 0;
        sew = 8 << t.vsew;
        num = (t.vlmul < 4) ? (1 << t.vlmul) : 1;
        den = (t.vlmul >= 5) ? (1 << (8 - t.vlmul)) : 1;
        return (VLEN * num) / (sew * den);
    endfunction

    task automatic model_reset();
        m_vss = mk_vss(1); m_vt = '0; m_vt.vill = 1'b1;
        m_vl = 0; m_vstart = 0; m_vxrm = 0; m_vxsat = 0;
    endtask

    task automatic model_step(input vec_t v);
        bit lg, touched;
        int vm;
        if (v.stall) return;
        lg      = ref_legal(v.vt);
        touched = (v.wr[4:0] != 0) || v.dirty;
        if (v.wr[4]) begin
            if (lg) begin m_vt = v.vt; m_vt.vill = 1'b0; end
            else begin m_vt = '0; m_vt.vill = 1'b1; m_vl = 0; end
        end
        if (v.wr[3] && !(v.wr[4] && !lg)) begin
            vm   = ref_vlmax(m_vt);
            m_vl = (int'(v.vl) < vm) ? int'(v.vl) : vm;
        end
        if (v.wr[2]) m_vstart = int'(v.vstart);
        if (v.wr[1]) m_vxrm   = int'(v.vxrm);
        if (v.wr[0]) m_vxsat  = int'(v.vxsat);
        if (v.wr[5]) m_vss = v.vss;
        else if (m_vss.vs != RISCV_V_VS_OFF && touched) m_vss.vs = RISCV_V_VS_DIRTY;
    endtask

    task automatic clear_inputs();
        {en_vss, en_vt, en_vl, en_vst, en_vxrm, en_vxsat} = 6'b0;
        stall = 1'b0; vec_dirty = 1'b0;
    endtask

    // Drive one vector for one cycle; returns #1 after the commit edge, strobes cleared
    task automatic apply(input vec_t v);
        {en_vss, en_vt, en_vl, en_vst, en_vxrm, en_vxsat} = v.wr;
        stall = v.stall; vec_dirty = v.dirty;
        d_vss = v.vss; d_vt = v.vt; d_vl.len = v.vl; d_vst.index = v.vstart;
        d_vxrm.rounding_mode = v.vxrm; d_vxsat.saturate = v.vxsat;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".vtype"},    64'(o_vt),           64'(m_vt));
        chk({tag, ".vl"},       64'(o_vl.len),       64'(m_vl));
        chk({tag, ".vlmax"},    64'(o_vlmax),        64'(ref_vlmax(m_vt)));
        chk({tag, ".vstart"},   64'(o_vst.index),    64'(m_vstart));
        chk({tag, ".vxrm"},     64'(o_vxrm),         64'(m_vxrm));
        chk({tag, ".vxsat"},    64'(o_vxsat),        64'(m_vxsat));
        chk({tag, ".vsstatus"}, 64'(o_vss),          64'(m_vss));
        chk({tag, ".vs_off"},   64'(o_off),          64'(m_vss.vs == RISCV_V_VS_OFF));
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        d_vss = '0; d_vt = '0; d_vl = '0; d_vst = '0; d_vxrm = '0; d_vxsat = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst.vill",   64'(o_vt.vill),   64'd1);
        chk("rst.vtype",  64'(o_vt),        64'h8000_0000);
        chk("rst.vl",     64'(o_vl.len),    64'd0);
        chk("rst.vlmax",  64'(o_vlmax),     64'd0);
        chk("rst.vs",     64'(o_vss),       64'(32'h0000_0200));
        chk("rst.vs_off", 64'(o_off),       64'd0);
        @(posedge clk);
        #1;

        //            wr       st  dty vs  vtype                  vl   vxrm vxsat  vill vl   vlmax vs
        tbl.push_back(mk(6'b011000, 0, 0, 0, mk_vt(0, 2, 0),  10,  0, 0,   0,   4,   4,   3));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(0, 3, 5),   0,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b100000, 0, 0, 0, mk_vt(0, 0, 0),   0,  0, 0,   1,   0,   0,   0));
        tbl.push_back(mk(6'b000010, 0, 1, 0, mk_vt(0, 0, 0),   0,  2, 0,   1,   0,   0,   0));
        tbl.push_back(mk(6'b100001, 0, 0, 2, mk_vt(0, 0, 0),   0,  0, 1,   1,   0,   0,   2));
        tbl.push_back(mk(6'b010000, 1, 0, 0, mk_vt(0, 0, 3),   0,  0, 0,   1,   0,   0,   2));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(0, 0, 3),   0,  0, 0,   0,   0, 128,   3));
        tbl.push_back(mk(6'b001000, 1, 0, 0, mk_vt(0, 0, 0),   3,  0, 0,   0,   0, 128,   3));
        tbl.push_back(mk(6'b001000, 0, 0, 0, mk_vt(0, 0, 0),   3,  0, 0,   0,   3, 128,   3));
        tbl.push_back(mk(6'b001000, 0, 0, 0, mk_vt(0, 0, 0), 200,  0, 0,   0, 128, 128,   3));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(0, 1, 0),   0,  0, 0,   0, 128,   8,   3));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(1, 0, 0),   0,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b011000, 0, 0, 0, mk_vt(0, 3, 7),   5,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b011000, 0, 0, 0, mk_vt(0, 0, 5),   5,  0, 0,   0,   2,   2,   3));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(0, 2, 5),   0,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b011000, 0, 0, 0, mk_vt(0, 3, 0),   9,  0, 0,   0,   2,   2,   3));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(0, 5, 0),   0,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b010000, 0, 0, 0, mk_vt(0, 0, 4),   0,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b100000, 0, 1, 1, mk_vt(0, 0, 0),   0,  0, 0,   1,   0,   0,   1));
        tbl.push_back(mk(6'b000000, 0, 1, 0, mk_vt(0, 0, 0),   0,  0, 0,   1,   0,   0,   3));
        tbl.push_back(mk(6'b011000, 0, 0, 0, mk_vt(0, 1, 7), 255,  0, 0,   0,   4,   4,   3));

        foreach (tbl[i]) begin
            model_step(tbl[i]);
            apply(tbl[i]);
            chk($sformatf("tbl%0d.vill", i),   64'(o_vt.vill),     64'(tbl[i].exp_vill));
            chk($sformatf("tbl%0d.vl", i),     64'(o_vl.len),      64'(tbl[i].exp_vl));
            chk($sformatf("tbl%0d.vlmax", i),  64'(o_vlmax),       64'(tbl[i].exp_vlmax));
            chk($sformatf("tbl%0d.vs", i),     64'(o_vss.vs),      64'(tbl[i].exp_vs));
            chk($sformatf("tbl%0d.vs_off", i), 64'(o_off),         64'(tbl[i].exp_off));
        end
        chk("tbl.vxrm",  64'(o_vxrm),  64'd2);
        chk("tbl.vxsat", 64'(o_vxsat), 64'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rv = mk(6'b0, 0, 0, 0, mk_vt(0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
            rv.wr[5]  = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < 5; b++) rv.wr[b] = ($urandom_range(0, 2) == 0);
            rv.stall  = ($urandom_range(0, 4) == 0);
            rv.dirty  = ($urandom_range(0, 3) == 0);
            rv.vss    = riscv_v_vsstatus_t'($urandom);
            rv.vt     = mk_vt(($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 255)) : 0,
                              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7))
                                                          : int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 7)));
            rv.vt.vta  = 1'($urandom);
            rv.vt.vma  = 1'($urandom);
            rv.vt.vill = 1'($urandom);
            rv.vl     = 8'($urandom_range(0, 255));
            rv.vstart = 7'($urandom);
            rv.vxrm   = 2'($urandom);
            rv.vxsat  = 1'($urandom);
            model_step(rv);
            apply(rv);
            chk_model("rnd");
        end

        // Commit a known vstart, then assert reset in the middle of another vstart write
        rv = mk(6'b000100, 0, 0, 0, mk_vt(0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        rv.vstart = 7'd9;
        model_step(rv);
        apply(rv);
        chk("pre_rst.vstart", 64'(o_vst.index), 64'd9);

        en_vst = 1'b1; d_vst.index = 7'd5;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.vstart_now", 64'(o_vst.index), 64'd0);
        chk("rst_mid.vill_now",   64'(o_vt.vill),   64'd1);
        chk("rst_mid.vs_now",     64'(o_vss.vs),    64'd1);
        @(posedge clk);
        #1;
        chk("rst_mid.vstart_hold", 64'(o_vst.index), 64'd0);
        clear_inputs();
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk_model("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
